mult_ctrl: RTL and testbench



---
 rtl/mult_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mult_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// Sequencer for the shift-and-add multiplier: drives register selects, Z-bus sources and shifts.
// Define MULT_SIGNED_EN to run 32 iterations for sign-extended 16-bit operands.
module mult_ctrl #(
  parameter int unsigned N_ITER = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [4:0] rd_enA,
  output logic [4:0] rd_enB,
  output logic [4:0] wr_en,
  output logic       add_en,
  output logic       shift_en,
  output logic       ppgen_en,
  output logic       ext_en,
  output logic       ext_sel,
  output logic       const_en,
  output logic       const_val,
  output logic       left_right,
  output logic       busy,
  output logic       done
);

`ifdef MULT_SIGNED_EN
  localparam int unsigned IterCount = 32;
`else
  localparam int unsigned IterCount = N_ITER;
`endif
  localparam logic [5:0] LastIter = 6'(IterCount - 1);

  localparam logic [4:0] SelNone = 5'b00000;
  localparam logic [4:0] SelR1   = 5'b00001;
  localparam logic [4:0] SelR2   = 5'b00010;
  localparam logic [4:0] SelR3   = 5'b00100;
  localparam logic [4:0] SelR4   = 5'b01000;
  localparam logic [4:0] SelR5   = 5'b10000;

  typedef enum logic [3:0] {
    StIdle,
    StLda,
    StLdb,
    StLdk,
    StClr,
    StPp,
    StAcc,
    StShl,
    StShr,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: if (start) state_d = StLda;
      StLda:  state_d = StLdb;
      StLdb:  state_d = StLdk;
      StLdk:  state_d = StClr;
      StClr: begin
        cnt_d   = '0;
        state_d = StPp;
      end
      StPp:   state_d = StAcc;
      StAcc:  state_d = StShl;
      StShl:  state_d = StShr;
      StShr: begin
        cnt_d   = cnt_q + 6'd1;
        state_d = (cnt_q == LastIter) ? StDone : StPp;
      end
      StDone: state_d = StIdle;
      // Unused encodings recover to idle.
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode: outputs depend on the state register only.
  always_comb begin
    rd_enA     = SelR1;
    rd_enB     = SelR1;
    wr_en      = SelNone;
    add_en     = 1'b0;
    shift_en   = 1'b0;
    ppgen_en   = 1'b0;
    ext_en     = 1'b0;
    ext_sel    = 1'b0;
    const_en   = 1'b0;
    const_val  = 1'b0;
    left_right = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      StIdle: busy = 1'b0;
      StLda: begin
        ext_en = 1'b1;
        wr_en  = SelR1;
      end
      StLdb: begin
        ext_en  = 1'b1;
        ext_sel = 1'b1;
        wr_en   = SelR2;
      end
      StLdk: begin
        const_en  = 1'b1;
        const_val = 1'b1;
        wr_en     = SelR5;
      end
      StClr: begin
        const_en = 1'b1;
        wr_en    = SelR4;
      end
      StPp: begin
        rd_enA   = SelR1;
        rd_enB   = SelR2;
        ppgen_en = 1'b1;
        wr_en    = SelR3;
      end
      StAcc: begin
        rd_enA = SelR4;
        rd_enB = SelR3;
        add_en = 1'b1;
        wr_en  = SelR4;
      end
      StShl: begin
        rd_enA     = SelR1;
        rd_enB     = SelR5;
        shift_en   = 1'b1;
        left_right = 1'b1;
        wr_en      = SelR1;
      end
      StShr: begin
        rd_enA   = SelR2;
        rd_enB   = SelR5;
        shift_en = 1'b1;
        wr_en    = SelR2;
      end
      StDone: begin
        rd_enA = SelR4;
        done   = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  a_rd_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot(rd_enA) && $onehot(rd_enB));
  a_src_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0({add_en, shift_en, ppgen_en, ext_en, const_en}));
  a_wr_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(wr_en));

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: per-cycle control schedule derived from cycle number, plus a small
// datapath model so the product on the A port can be compared against a*b.
module tb_mult_ctrl;

`ifdef MULT_SIGNED_EN
  localparam int NIt = 32;
`else
  localparam int NIt = 16;
`endif
  localparam int DoneCyc = 5 + 4 * NIt;
  localparam int Period  = DoneCyc + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [4:0] rd_enA, rd_enB, wr_en;
  logic add_en, shift_en, ppgen_en, ext_en, ext_sel, const_en, const_val, left_right;
  logic busy, done;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] rf [1:5];
  logic [31:0] z, z_s;
  logic [4:0]  wr_s = '0;
  logic [25:0] act;

  mult_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_enA(rd_enA), .rd_enB(rd_enB), .wr_en(wr_en),
    .add_en(add_en), .shift_en(shift_en), .ppgen_en(ppgen_en),
    .ext_en(ext_en), .ext_sel(ext_sel), .const_en(const_en), .const_val(const_val),
    .left_right(left_right), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign act = {rd_enA, rd_enB, wr_en, add_en, shift_en, ppgen_en, ext_en, ext_sel,
                const_en, const_val, left_right, busy, done};

  function automatic logic [31:0] sel_read(input logic [4:0] oh);
    logic [31:0] r = '0;
    for (int i = 0; i < 5; i++) if (oh[i]) r |= rf[i + 1];
    return r;
  endfunction

  // Datapath model: Z bus from the enabled source, written to the selected register.
  always_comb begin
    logic [31:0] a, b;
    a = sel_read(rd_enA);
    b = sel_read(rd_enB);
    z = '0;
    if (add_en) z = a + b;
    if (shift_en) z = left_right ? (a << b[4:0]) : (a >> b[4:0]);
    if (ppgen_en) z = b[0] ? a : 32'h0;
    if (ext_en) z = ext_sel ? op_b : op_a;
    if (const_en) z = {31'h0, const_val};
  end

  always @(negedge clk) begin
    z_s  <= z;
    wr_s <= wr_en;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) if (wr_s[i]) rf[i + 1] <= z_s;
  end

  function automatic logic [4:0] oh(input int r);
    return 5'(1 << (r - 1));
  endfunction

  // Expected outputs k cycles after the start edge (k = 0 or beyond DONE means idle).
  function automatic logic [25:0] exp_vec(input int k);
    logic [4:0] ra = 5'b00001, rb = 5'b00001, wr = 5'b00000;
    logic add = 0, sh = 0, pp = 0, ext = 0, es = 0, ce = 0, cv = 0, lr = 0, bz = 0, dn = 0;
    int p;
    bz = (k >= 1 && k <= DoneCyc);
    if (k == 1) begin ext = 1; wr = oh(1); end
    else if (k == 2) begin ext = 1; es = 1; wr = oh(2); end
    else if (k == 3) begin ce = 1; cv = 1; wr = oh(5); end
    else if (k == 4) begin ce = 1; wr = oh(4); end
    else if (k == DoneCyc) begin ra = oh(4); dn = 1; end
    else if (k >= 5 && k < DoneCyc) begin
      p = (k - 5) % 4;
      if (p == 0) begin ra = oh(1); rb = oh(2); pp = 1; wr = oh(3); end
      else if (p == 1) begin ra = oh(4); rb = oh(3); add = 1; wr = oh(4); end
      else if (p == 2) begin ra = oh(1); rb = oh(5); sh = 1; lr = 1; wr = oh(1); end
      else begin ra = oh(2); rb = oh(5); sh = 1; wr = oh(2); end
    end
    return {ra, rb, wr, add, sh, pp, ext, es, ce, cv, lr, bz, dn};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [15:0] h = 16'($urandom_range(0, 16'hFFFF));
`ifdef MULT_SIGNED_EN
    return {{16{h[15]}}, h};
`else
    return {16'h0, h};
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (act !== exp_vec(0)) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want %h", act, exp_vec(0));
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (act !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got %h want %h", i, act, exp_vec(0));
      end
    end
  endtask

  task automatic test_mult(input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] want = a * b;
    op_a = a;
    op_b = b;
    start = 1'b1;
    for (int k = 1; k <= Period; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      n_checks++;
      if (act !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL %s ctrl cycle %0d: got %h want %h", name, k, act, exp_vec(k));
      end
      if (k == DoneCyc) begin
        n_checks++;
        if (sel_read(rd_enA) !== want) begin
          n_fail++;
          $display("FAIL %s product: got %h want %h", name, sel_read(rd_enA), want);
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    int n_done = 0;
    op_a = 32'd123;
    op_b = 32'd45;
    start = 1'b1;
    for (int k = 1; k <= Period + 2; k++) begin
      @(negedge clk);
      start = (k == 20 || k == DoneCyc);
      if (done) n_done++;
      n_checks++;
      if (act !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL ignore_start cycle %0d: got %h want %h", k, act, exp_vec(k));
      end
    end
    start = 1'b0;
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL ignore_start done_count: got %0d want 1", n_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    op_a = 32'h0000_1234;
    op_b = 32'h0000_0056;
    want = op_a * op_b;
    start = 1'b1;
    for (int k = 1; k <= 2 * Period; k++) begin
      @(negedge clk);
      if (k == Period + 1) start = 1'b0;
      n_checks++;
      if (act !== exp_vec(k % Period)) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %h want %h", k, act, exp_vec(k % Period));
      end
      if (k % Period == DoneCyc) begin
        n_checks++;
        if (sel_read(rd_enA) !== want) begin
          n_fail++;
          $display("FAIL back_to_back product: got %h want %h", sel_read(rd_enA), want);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    op_a = 32'd99;
    op_b = 32'd77;
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (act !== exp_vec(0)) begin
      n_fail++;
      $display("FAIL mid_reset cycle 31: got %h want %h", act, exp_vec(0));
    end
    rst = 1'b0;
    @(negedge clk);
    test_mult(32'd1000, 32'd2000, "after_reset");
  endtask

  initial begin
    for (int i = 1; i <= 5; i++) rf[i] = '0;
    test_reset();
    test_mult(32'h0000_0007, 32'h0000_0006, "mul_7x6");
    test_mult(32'h0000_FFFF, 32'h0000_FFFF, "mul_ffff");
    test_mult(32'h0000_0000, 32'h0000_BEEF, "mul_zero");
`ifdef MULT_SIGNED_EN
    test_mult(32'hFFFF_FFFD, 32'h0000_0005, "mul_neg3x5");
    test_mult(32'hFFFF_8000, 32'hFFFF_FFFF, "mul_minxneg1");
`endif
    for (int i = 0; i < 3; i++) test_mult(rand_op(), rand_op(), "mul_rand");
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
